// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker: state encoding,
// gate_out bit positions and the expected-vector function.
package gate_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int BIT_AND   = 0;
  localparam int BIT_OR    = 1;
  localparam int BIT_NOT_A = 2;
  localparam int BIT_NOT_B = 3;
  localparam int BIT_NAND  = 4;
  localparam int BIT_NOR   = 5;
  localparam int BIT_XOR   = 6;
  localparam int BIT_XNOR  = 7;

  function automatic logic [7:0] expected_vec(input logic a, input logic b);
    logic [7:0] v;
    v            = '0;
    v[BIT_AND]   = a & b;
    v[BIT_OR]    = a | b;
    v[BIT_NOT_A] = ~a;
    v[BIT_NOT_B] = ~b;
    v[BIT_NAND]  = ~(a & b);
    v[BIT_NOR]   = ~(a | b);
    v[BIT_XOR]   = a ^ b;
    v[BIT_XNOR]  = ~(a ^ b);
    return v;
  endfunction

endpackage

// File: rtl/gate_truth_checker_if.sv
// Bus between the checker and the two-input gate block: stimulus a/b out,
// eight gate results back.
interface gate_truth_checker_if;
  logic       a;
  logic       b;
  logic [7:0] gate_out;

  modport master (output a, output b, input gate_out);
  modport slave  (input a, input b, output gate_out);
endinterface

// File: rtl/gate_expected.sv
// Combinational golden model of the gate block: (a,b) -> expected gate_out.
module gate_expected
  import gate_chk_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [7:0] expected
);
  assign expected = expected_vec(a, b);
endmodule

// File: rtl/gate_truth_checker.sv
// Self-test sequencer that sweeps the gate block through its truth table and
// compares its outputs. First-failure capture: define GATE_CHK_FIRST_FAIL_EN.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  gate_truth_checker_if.master  gate,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [3:0]            err_vec,
  output logic [1:0]            first_fail_idx,
  output logic [7:0]            first_fail_mask
);

  localparam int SC_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int PC_W = (NUM_PASSES < 2) ? 1 : $clog2(NUM_PASSES);

  state_t           state, state_next;
  logic [1:0]       idx;
  logic [PC_W-1:0]  pass_cnt;
  logic [SC_W-1:0]  settle_cnt;
  logic             a_r, b_r, pass_r;
  logic [7:0]       expected, diff;
  logic             mismatch, last_vec, more_passes;
  logic [ERR_W-1:0] err_count_next;

  gate_expected u_expected (
    .a        (a_r),
    .b        (b_r),
    .expected (expected)
  );

  assign diff        = expected ^ gate.gate_out;
  assign mismatch    = (state == ST_CHECK) && (diff != 8'h00);
  assign last_vec    = (idx == 2'd3);
  assign more_passes = (pass_cnt != PC_W'(NUM_PASSES - 1));

  always_comb begin
    err_count_next = err_count;
    if (mismatch && (err_count != {ERR_W{1'b1}}))
      err_count_next = err_count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_DRIVE;
      ST_DRIVE:  state_next = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
      ST_SETTLE: if (settle_cnt <= SC_W'(1)) state_next = ST_CHECK;
      ST_CHECK:  state_next = (last_vec && !more_passes) ? ST_DONE : ST_DRIVE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // pass is resolved on the way into DONE so it is already valid with the pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      a_r        <= 1'b0;
      b_r        <= 1'b0;
      pass_r     <= 1'b0;
      err_count  <= '0;
      err_vec    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx       <= '0;
            pass_cnt  <= '0;
            pass_r    <= 1'b0;
            err_count <= '0;
            err_vec   <= '0;
          end
        end
        ST_DRIVE: begin
          a_r        <= idx[1];
          b_r        <= idx[0];
          settle_cnt <= SC_W'(SETTLE_CYCLES);
        end
        ST_SETTLE: settle_cnt <= settle_cnt - 1'b1;
        ST_CHECK: begin
          err_count <= err_count_next;
          if (mismatch) err_vec[idx] <= 1'b1;
          if (!last_vec) begin
            idx <= idx + 2'd1;
          end else if (more_passes) begin
            idx      <= '0;
            pass_cnt <= pass_cnt + 1'b1;
          end else begin
            pass_r <= (err_count_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic       ff_valid;
  logic [1:0] ff_idx;
  logic [7:0] ff_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
      ff_mask  <= '0;
    end else if (state == ST_IDLE && start) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
      ff_mask  <= '0;
    end else if (mismatch && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_idx   <= idx;
      ff_mask  <= diff;
    end
  end

  assign first_fail_idx  = ff_idx;
  assign first_fail_mask = ff_mask;
`else
  assign first_fail_idx  = 2'd0;
  assign first_fail_mask = 8'h00;
`endif

  assign gate.a = a_r;
  assign gate.b = b_r;
  assign busy   = (state != ST_IDLE) && (state != ST_DONE);
  assign done   = (state == ST_DONE);
  assign pass   = pass_r;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: three parameterisations driven by a
// behavioural gate block with selectable faults.
module tb_gate_truth_checker;

  typedef struct {
    logic [7:0] cnt;
    logic [3:0] vec;
    logic       pass;
    logic [1:0] idx;
    logic [7:0] mask;
    int         len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_v [3];
  int   fault   [3];

  logic       busy_w [3];
  logic       done_w [3];
  logic       pass_w [3];
  logic [7:0] cnt_w  [3];
  logic [3:0] vec_w  [3];
  logic [1:0] idx_w  [3];
  logic [7:0] mask_w [3];
  logic [1:0] ab_w   [3];

  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] golden(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~b, ~a, a | b, a & b};
  endfunction

  // mode 0 healthy, 1 xor stuck 0, 2 all inverted, 3 nand stuck 1
  function automatic logic [7:0] fault_model(input int mode, input logic a, input logic b);
    logic [7:0] g;
    g = golden(a, b);
    case (mode)
      1: g[6] = 1'b0;
      2: g = ~g;
      3: g[4] = 1'b1;
      default: ;
    endcase
    return g;
  endfunction

  function automatic exp_t model(input int mode, input int passes, input int errw, input int settle);
    exp_t r;
    int   maxc;
    bit   first;
    logic [1:0] v;
    logic [7:0] g, act;
    r.cnt = '0; r.vec = '0; r.idx = '0; r.mask = '0;
    r.len = 1 + passes * 4 * (2 + settle);
    maxc  = (1 << errw) - 1;
    first = 1'b0;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < 4; i++) begin
        v   = 2'(i);
        g   = golden(v[1], v[0]);
        act = fault_model(mode, v[1], v[0]);
        if (g !== act) begin
          if (int'(r.cnt) < maxc) r.cnt = r.cnt + 8'd1;
          r.vec[i] = 1'b1;
          if (!first) begin
            first  = 1'b1;
            r.idx  = v;
            r.mask = g ^ act;
          end
        end
      end
    end
    r.pass = (r.cnt == 8'd0);
`ifndef GATE_CHK_FIRST_FAIL_EN
    r.idx  = '0;
    r.mask = '0;
`endif
    return r;
  endfunction

  gate_truth_checker_if if0 ();
  gate_truth_checker_if if1 ();
  gate_truth_checker_if if2 ();

  always_comb if0.gate_out = fault_model(fault[0], if0.a, if0.b);
  always_comb if1.gate_out = fault_model(fault[1], if1.a, if1.b);
  always_comb if2.gate_out = fault_model(fault[2], if2.a, if2.b);

  gate_truth_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(1), .ERR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .gate(if0),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(cnt0),
    .err_vec(vec_w[0]), .first_fail_idx(idx_w[0]), .first_fail_mask(mask_w[0]));

  gate_truth_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(1), .ERR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .gate(if1),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(cnt1),
    .err_vec(vec_w[1]), .first_fail_idx(idx_w[1]), .first_fail_mask(mask_w[1]));

  gate_truth_checker #(.SETTLE_CYCLES(0), .NUM_PASSES(2), .ERR_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .gate(if2),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(cnt2),
    .err_vec(vec_w[2]), .first_fail_idx(idx_w[2]), .first_fail_mask(mask_w[2]));

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = {6'b0, cnt1};
  assign cnt_w[2] = cnt2;
  assign ab_w[0]  = {if0.a, if0.b};
  assign ab_w[1]  = {if1.a, if1.b};
  assign ab_w[2]  = {if2.a, if2.b};

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input int u, input string tag);
    check_output({tag, "_busy"}, 32'(busy_w[u]), 32'd0);
    check_output({tag, "_done"}, 32'(done_w[u]), 32'd0);
    check_output({tag, "_pass"}, 32'(pass_w[u]), 32'd0);
    check_output({tag, "_cnt"},  32'(cnt_w[u]),  32'd0);
    check_output({tag, "_vec"},  32'(vec_w[u]),  32'd0);
    check_output({tag, "_ab"},   32'(ab_w[u]),   32'd0);
    check_output({tag, "_ffidx"},  32'(idx_w[u]),  32'd0);
    check_output({tag, "_ffmask"}, 32'(mask_w[u]), 32'd0);
  endtask

  // One run: pulse start, watch the sweep, then compare against the scoreboard
  task automatic apply_stimulus(input int u, input int mode, input int passes, input int errw,
                                input int settle, input bit check_ab, input bit poke_busy,
                                input string tag);
    exp_t e;
    int   n;
    fault[u] = mode;
    sb.push_back(model(mode, passes, errw, settle));
    @(negedge clk) start_v[u] = 1'b1;
    @(negedge clk) start_v[u] = 1'b0;
    for (n = 1; n <= 200; n++) begin
      if (n > 1) @(negedge clk);
      if (poke_busy && n == 5) start_v[u] = 1'b1;
      if (poke_busy && n == 7) start_v[u] = 1'b0;
      if (n == 1) check_output({tag, "_busy_rise"}, 32'(busy_w[u]), 32'd1);
      if (check_ab && n % 4 == 3 && n < 16)
        check_output({tag, "_ab_seq"}, 32'(ab_w[u]), 32'((n - 3) / 4));
      if (done_w[u]) break;
    end
    e = sb.pop_front();
    check_output({tag, "_len"},    32'(n),          32'(e.len));
    check_output({tag, "_busy_at_done"}, 32'(busy_w[u]), 32'd0);
    check_output({tag, "_pass"},   32'(pass_w[u]),  32'(e.pass));
    check_output({tag, "_cnt"},    32'(cnt_w[u]),   32'(e.cnt));
    check_output({tag, "_vec"},    32'(vec_w[u]),   32'(e.vec));
    check_output({tag, "_ffidx"},  32'(idx_w[u]),   32'(e.idx));
    check_output({tag, "_ffmask"}, 32'(mask_w[u]),  32'(e.mask));
    @(negedge clk);
    check_output({tag, "_done_pulse"}, 32'(done_w[u]), 32'd0);
    check_output({tag, "_pass_hold"},  32'(pass_w[u]), 32'(e.pass));
  endtask

  initial begin
    int done_seen;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      fault[i]   = 0;
    end
    repeat (3) @(negedge clk);
    check_idle_reset(0, "reset0");
    check_output("reset1_cnt", 32'(cnt_w[1]), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] healthy gate, default parameters");
    apply_stimulus(0, 0, 1, 8, 2, 1'b1, 1'b0, "healthy");

    $display("[TB] xor stuck at 0");
    apply_stimulus(0, 1, 1, 8, 2, 1'b1, 1'b0, "xor_stuck");

    $display("[TB] all outputs inverted, ERR_W=2");
    apply_stimulus(1, 2, 1, 2, 2, 1'b1, 1'b0, "inverted");

    $display("[TB] two passes, no settle, nand stuck at 1");
    apply_stimulus(2, 3, 2, 8, 0, 1'b0, 1'b0, "nand_stuck");

    $display("[TB] start re-pulsed while busy");
    apply_stimulus(0, 0, 1, 8, 2, 1'b0, 1'b1, "busy_poke");

    $display("[TB] reset asserted during SETTLE");
    fault[0] = 1;
    @(negedge clk) start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    check_output("mid_busy", 32'(busy_w[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_idle_reset(0, "mid_reset");
    check_output("mid_reset1_vec", 32'(vec_w[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_w[0]) done_seen++;
    end
    check_output("mid_no_done", 32'(done_seen), 32'd0);
    check_output("mid_idle_busy", 32'(busy_w[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

- Self-checking sequencer that sits directly around the two-input logic-gate block.
- Upstream role: drives the block's `a`/`b` inputs through the full truth table (00, 01, 10, 11).
- Downstream role: samples the block's eight gate outputs after a programmable settle time and compares them against internally computed expected values.
- Reports pass/fail, a saturating mismatch count, a per-vector fail map, and optional first-failure capture. Used for on-chip or bench self-test of the gate block.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles between driving a vector and sampling outputs; 0 is legal.
- `NUM_PASSES`, default 1: number of full truth-table sweeps per run; must be ≥1.
- `ERR_W`, default 8: width of the mismatch counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  — single clock; everything registered on its rising edge.
- `rst_n`  in  1  — asynchronous assert, active-low.
- `start`  in  1  — run request, sampled in IDLE only.
- `a`  out  1  — gate-block input A (registered).
- `b`  out  1  — gate-block input B (registered).
- `gate_out`  in  8  — gate-block outputs; bit0 and, 1 or, 2 not_a, 3 not_b, 4 nand, 5 nor, 6 xor, 7 xnor.
- `busy`  out  1  — high from start acceptance until DONE.
- `done`  out  1  — one-cycle pulse at end of run.
- `pass`  out  1  — high when the last completed run had zero mismatches.
- `err_count`  out  ERR_W  — number of mismatching vector checks, saturating.
- `err_vec`  out  4  — bit i set if vector index i ({a,b}=i) ever mismatched in the run.
- `first_fail_idx`  out  2  — vector index of the first mismatch.
- `first_fail_mask`  out  8  — XOR of expected vs `gate_out` at the first mismatch.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE:
  - On `start`=1: clear `err_count`, `err_vec`, `pass`, `first_fail_*`; vector index = 0; pass counter = 0; go to DRIVE.
- DRIVE (1 cycle):
  - Register `{a,b}` = index; load settle counter with `SETTLE_CYCLES`.
  - Go to SETTLE, or straight to CHECK if `SETTLE_CYCLES`=0.
- SETTLE: decrement the counter; go to CHECK when it reaches 1.
- CHECK (1 cycle):
  - expected = {~(a^b), a^b, ~(a|b), ~(a&b), ~b, ~a, a|b, a&b}, computed from the registered `a`,`b`.
  - If expected ≠ `gate_out`: `err_count`+1 (holds at all-ones), set `err_vec[index]`, capture first-fail if not yet captured.
  - Then:
    - index < 3: index+1, go to DRIVE.
    - index = 3 and passes remain: index = 0, pass counter +1, go to DRIVE.
    - otherwise: go to DONE.
- DONE (1 cycle):
  - `done`=1; `pass` = (`err_count`==0); go to IDLE.
- Results hold until the next accepted `start`.
- `start` outside IDLE is ignored. `start` held high re-launches a run on the cycle after DONE returns to IDLE.
- Mismatches are counted once per vector check, not per bit.
- `err_vec` accumulates (OR) across passes.

## Timing
- Reset values:
  - `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `err_vec`=0, `first_fail_idx`=0, `first_fail_mask`=0.
  - State = IDLE.
- Reset mid-run: immediate return to reset values; no `done` pulse.
- Cycles per vector: 2+`SETTLE_CYCLES`.
- `start` high at edge k → `busy` high and DRIVE from edge k+1.
- `done` high in the cycle beginning at edge k+1+`NUM_PASSES`·4·(2+`SETTLE_CYCLES`).
  - Default: `done` high 17 cycles after the `start` edge.
- `busy` falls in the same cycle `done` rises.
- `pass` and final counts are valid when `done` is high.
- `gate_out` is sampled at the end of the CHECK cycle and treated as combinational from `a`/`b`.

## Configuration
- Macro `GATE_CHK_FIRST_FAIL_EN`.
- Defined: first-fail capture logic is present; `first_fail_idx`/`first_fail_mask` latch on the first mismatch of a run.
- Undefined: capture registers are omitted; both ports are tied to 0. All other behaviour is identical.

## Structure
- Shared package/include `gate_chk_pkg` holds:
  - state encodings;
  - `gate_out` bit-position constants;
  - the expected-vector function.
- One sub-module, `gate_expected`: combinational, (a,b) → 8-bit expected vector. The gate block's own bench reuses it as its golden model.

## Test plan
- Correct gate model, default params, `start` pulse → `done` at +17 cycles, `pass`=1, `err_count`=0, `err_vec`=0000, `a`/`b` sequence 00,01,10,11.
- xor output stuck at 0 → fails on vectors 01 and 10: `err_count`=2, `err_vec`=0110, `first_fail_idx`=1, `first_fail_mask`=8'h40, `pass`=0.
- All outputs inverted, `ERR_W`=2 → all four vectors fail: `err_count` saturates at 3, `err_vec`=1111, `first_fail_mask`=8'hFF.
- `NUM_PASSES`=2, `SETTLE_CYCLES`=0, nand stuck at 1 → vector 11 fails in both passes: `err_count`=2, `err_vec`=1000, `done` at +17 cycles.
- `start` pulsed again while `busy` → ignored, run length unchanged. `rst_n` low during SETTLE → outputs return to reset values and no `done` pulse appears.
